// File: rtl/divider_pkg.sv
// Shared definitions for the sequential non-restoring divider.
// Optional feature macro: DIV_ZERO_FLAG_EN (adds the div_zero output).
package divider_pkg;

   localparam int unsigned DIV_WIDTH = 32;
   localparam int unsigned CNT_W     = $clog2(DIV_WIDTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      FIX    = 2'd2,
      DONE   = 2'd3
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational non-restoring division iteration on magnitudes.
// p is the signed partial remainder, a the quotient/dividend shift register,
// d the divisor magnitude (zero-extended to WIDTH+1 bits).
module div_step
   import divider_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   p,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH:0]   d,
   output logic [WIDTH:0]   p_next,
   output logic [WIDTH-1:0] a_next
);

   logic [WIDTH:0] p_shift;

   // Shift {p,a} left, then subtract or add d depending on the old sign of p.
   always_comb begin
      p_shift = {p[WIDTH-1:0], a[WIDTH-1]};
      // Wrap-around in WIDTH+1 bits is harmless: the true result always fits.
      if (p[WIDTH]) begin
         p_next = p_shift + d;
      end else begin
         p_next = p_shift - d;
      end
      a_next = {a[WIDTH-2:0], ~p_next[WIDTH]};
   end

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential signed divider: quotient (LO) and remainder (HI) via a
// non-restoring shift/add-sub loop, WIDTH iterations plus fix-up.
// Optional feature macro: DIV_ZERO_FLAG_EN adds the div_zero output flag.
module nonrestoring_divider
   import divider_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic [2*WIDTH-1:0] result,
   output logic               busy,
   output logic               done
`ifdef DIV_ZERO_FLAG_EN
   ,
   output logic               div_zero
`endif
);

   localparam int unsigned CntW = $clog2(WIDTH);

   div_state_e       state_q, state_d;
   logic [CntW-1:0]  count_q, count_d;
   logic [WIDTH:0]   p_q, p_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH:0]   d_q, d_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   step_p;
   logic [WIDTH-1:0] step_a;
   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH-1:0] divisor_mag;
   logic [WIDTH-1:0] fix_r;

   // -2^(WIDTH-1) negates to itself, which read as unsigned is the exact magnitude.
   assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
   assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;

   // Final restoring correction: only the low WIDTH bits survive into the output.
   assign fix_r = p_q[WIDTH] ? (p_q[WIDTH-1:0] + d_q[WIDTH-1:0]) : p_q[WIDTH-1:0];

   div_step #(
      .WIDTH (WIDTH)
   ) u_div_step (
      .p      (p_q),
      .a      (a_q),
      .d      (d_q),
      .p_next (step_p),
      .a_next (step_a)
   );

   // Next-state, datapath and output-load decisions.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      p_d         = p_q;
      a_d         = a_q;
      d_d         = d_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      zero_d      = zero_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      done_d      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
               r_neg_d = dividend[WIDTH-1];
               p_d     = '0;
               count_d = '0;
               if (divisor == '0) begin
                  // Keep the raw dividend so it can be returned as the remainder.
                  zero_d  = 1'b1;
                  a_d     = dividend;
                  d_d     = '0;
                  state_d = DONE;
               end else begin
                  zero_d  = 1'b0;
                  a_d     = dividend_mag;
                  d_d     = {1'b0, divisor_mag};
                  state_d = DIVIDE;
               end
            end
         end
         DIVIDE: begin
            p_d     = step_p;
            a_d     = step_a;
            count_d = count_q + CntW'(1);
            if (count_q == CntW'(WIDTH - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            quotient_d  = q_neg_q ? -a_q : a_q;
            remainder_d = r_neg_q ? -fix_r : fix_r;
            state_d     = DONE;
         end
         DONE: begin
            done_d = 1'b1;
            if (zero_q) begin
               quotient_d  = '1;
               remainder_d = a_q;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         p_q         <= '0;
         a_q         <= '0;
         d_q         <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         zero_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         p_q         <= p_d;
         a_q         <= a_d;
         d_q         <= d_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         zero_q      <= zero_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         done_q      <= done_d;
      end
   end

`ifdef DIV_ZERO_FLAG_EN
   logic div_zero_q;

   // Zero-divisor flag: raised together with done, dropped on the next acceptance.
   always_ff @(posedge clock) begin
      if (reset) begin
         div_zero_q <= 1'b0;
      end else if (state_q == IDLE && start) begin
         div_zero_q <= 1'b0;
      end else if (state_q == DONE) begin
         div_zero_q <= zero_q;
      end
   end

   assign div_zero = div_zero_q;
`endif

   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign result    = {remainder_q, quotient_q};
   assign busy      = (state_q == DIVIDE) || (state_q == FIX);
   assign done      = done_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Self-checking bench for nonrestoring_divider: vector table, random operands,
// and hand-written sequences for ignored starts and mid-operation reset.
module tb_nonrestoring_divider;

   localparam int W = 32;

   logic           clock;
   logic           reset;
   logic           start;
   logic [W-1:0]   dividend;
   logic [W-1:0]   divisor;
   logic [W-1:0]   quotient;
   logic [W-1:0]   remainder;
   logic [2*W-1:0] result;
   logic           busy;
   logic           done;
`ifdef DIV_ZERO_FLAG_EN
   logic           div_zero;
`endif

   nonrestoring_divider #(
      .WIDTH (W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .result    (result),
      .busy      (busy),
      .done      (done)
`ifdef DIV_ZERO_FLAG_EN
      ,
      .div_zero  (div_zero)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      bit           z;
   } vec_t;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      bit           z;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] q, input logic [W-1:0] r, input bit z);
      vec_t v;
      v.a = a;
      v.b = b;
      v.q = q;
      v.r = r;
      v.z = z;
      return v;
   endfunction

   // Scoreboard side: compare every done pulse against the oldest expectation.
   always @(negedge clock) begin
      if (!reset && done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=done required=no_done");
         end else begin
            mon_e = sb.pop_front();
            check("quotient", 64'(quotient), 64'(mon_e.q));
            check("remainder", 64'(remainder), 64'(mon_e.r));
            check("result", result, {mon_e.r, mon_e.q});
            check("busy_at_done", 64'(busy), 64'(0));
`ifdef DIV_ZERO_FLAG_EN
            check("div_zero", 64'(div_zero), 64'(mon_e.z));
`endif
         end
      end
   end

   // Drive one operation; accepted on the next rising edge.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                         input logic [W-1:0] r, input bit z, input bit push);
      exp_t e;
      e.q = q;
      e.r = r;
      e.z = z;
      if (push) sb.push_back(e);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      check("busy_after_accept", 64'(busy), 64'(!z));
   endtask

   // Count edges after acceptance until done; optionally inject a 9/3 start at edge inject_at+1.
   task automatic wait_done(input int exp_lat, input int inject_at);
      int n = 0;
      bit seen = 1'b0;
      while (n < 100 && !seen) begin
         @(posedge clock);
         #1;
         n++;
         if (inject_at != 0 && n == inject_at) begin
            dividend = 32'd9;
            divisor  = 32'd3;
            start    = 1'b1;
         end else if (inject_at != 0 && n == inject_at + 1) begin
            start = 1'b0;
         end
         if (done === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=no_done required=done_after_%0d", exp_lat);
      end else begin
         check("latency", 64'(n), 64'(exp_lat));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = mk(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      vecs[1]  = mk(-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
      vecs[2]  = mk(32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0);
      vecs[3]  = mk(-32'sd100, -32'sd7, 32'd14, -32'sd2, 1'b0);
      vecs[4]  = mk(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
      vecs[5]  = mk(32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0);
      vecs[6]  = mk(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
      vecs[7]  = mk(32'd0, 32'd5, 32'd0, 32'd0, 1'b0);
      vecs[8]  = mk(32'd7, 32'd100, 32'd0, 32'd7, 1'b0);
      vecs[9]  = mk(32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0, 1'b0);
      vecs[10] = mk(-32'sd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
      vecs[11] = mk(32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 1'b0);
      vecs[12] = mk(32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0);
      vecs[13] = mk(32'd123456789, -32'sd1000, 32'hFFFE_1DC0, 32'd789, 1'b0);
      vecs[14] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
      vecs[15] = mk(32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 1'b0);

      reset    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      @(posedge clock);
      #1;
      // Start held during reset must be ignored.
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      reset = 1'b0;
      check("reset_quotient", 64'(quotient), 64'(0));
      check("reset_remainder", 64'(remainder), 64'(0));
      check("reset_result", result, 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_done", 64'(done), 64'(0));
`ifdef DIV_ZERO_FLAG_EN
      check("reset_div_zero", 64'(div_zero), 64'(0));
`endif

      foreach (vecs[i]) begin
         launch(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, 1'b1);
         wait_done(vecs[i].z ? 1 : W + 2, 0);
      end

      // Random operands against the language's truncating division.
      for (int k = 0; k < 8; k++) begin
         int sa;
         int sd;
         sa = int'($urandom);
         sd = int'($urandom) >>> $urandom_range(0, 28);
         if (sd == 0) sd = 3;
         if (sd == -1 && sa == 32'sh8000_0000) sa = 12345;
         launch(sa, sd, sa / sd, sa % sd, 1'b0, 1'b1);
         wait_done(W + 2, 0);
      end

      // Second start while busy: ignored, original 100/7 completes on time.
      launch(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
      wait_done(W + 2, 4);

      // Outputs hold while idle.
      repeat (10) @(posedge clock);
      #1;
      check("hold_quotient", 64'(quotient), 64'(14));
      check("hold_remainder", 64'(remainder), 64'(2));

      // Start held into the DONE state with new operands: not resampled.
      sb.push_back('{q: 32'hFFFF_FFFF, r: 32'd5, z: 1'b1});
      dividend = 32'd5;
      divisor  = 32'd0;
      start    = 1'b1;
      @(posedge clock);
      #1;
      dividend = 32'd9;
      divisor  = 32'd3;
      @(posedge clock);
      #1;
      start = 1'b0;
      check("zero_done_pulse", 64'(done), 64'(1));
      repeat (40) @(posedge clock);
      #1;
      check("idle_after_done_state_start", 64'(busy), 64'(0));

      // Reset in the middle of a division: abort, clear outputs, no done.
      launch(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
      repeat (9) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_quotient", 64'(quotient), 64'(0));
      check("abort_remainder", 64'(remainder), 64'(0));
      check("abort_result", result, 64'(0));
      check("abort_done", 64'(done), 64'(0));
      repeat (40) @(posedge clock);
      #1;
      check("abort_still_idle", 64'(busy), 64'(0));
      check("abort_outputs_clear", result, 64'(0));

      check("scoreboard_drained", 64'(sb.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
